// File: rtl/display_pkg.sv
// Shared types and constants for the 7-segment display blocks.
// Segment encodings are active-high internally, bit order {g,f,e,d,c,b,a}.
package display_pkg;

    typedef enum logic [1:0] {IDLE, SHOW, BLANK} state_t;

    localparam logic [6:0] SEG_OFF  = 7'b0000000;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    // Entry 15 first: values 10..15 map to the dash error glyph.
    localparam logic [15:0][6:0] GLYPH_TABLE = {
        SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD-to-7-segment decoder with a blank override.
// Output is active-high, bit order {g,f,e,d,c,b,a}.
module seg7_decoder
    import display_pkg::*;
(
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_OFF : GLYPH_TABLE[value];

endmodule

// File: rtl/display_scanner.sv
// Time-multiplexed common-anode 7-segment scanner driven by an asynchronous
// scan tick, with dead-time between digits and leading-zero blanking.
module display_scanner
    import display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int BLANK_TICKS = 1,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  scanTick,
    input  logic [4*DIGITS-1:0]   digitsIn,
    input  logic [DIGITS-1:0]     dotMask,
    input  logic                  blankZeros,
    output logic [6:0]            segments,
    output logic                  dot,
    output logic [DIGITS-1:0]     anodes,
    output logic                  frameStart
);

    localparam int              IDX_W      = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam logic [3:0]      BLANK_LOAD = (BLANK_TICKS > 0) ? 4'(BLANK_TICKS - 1) : 4'd0;
    localparam logic            POL        = (ACTIVE_LOW != 0);

    logic                  sync_p0, sync_p1, sync_p2, step_p3;

    state_t                state, nxt_state;
    logic [IDX_W-1:0]      index, nxt_index;
    logic [3:0]            blank_cnt, nxt_cnt;
    logic [4*DIGITS-1:0]   shadow_digits, nxt_digits;
    logic [DIGITS-1:0]     shadow_dots, nxt_dots;
    logic                  shadow_bz, nxt_bz;
    logic                  nxt_frame;
    logic                  advance;

    logic [DIGITS-1:0]     lz_mask;
    logic                  zero_run;
    logic [3:0]            cur_value;
    logic                  cur_blank;
    logic [6:0]            dec_seg;
    logic                  lit;
    logic [6:0]            seg_lit;
    logic                  dot_lit;
    logic [DIGITS-1:0]     anode_lit;

    // Next-state logic; outputs are registered from the next-state view so
    // the newly latched frame data is visible in the same cycle it is shown.
    always_comb begin
        nxt_state  = state;
        nxt_index  = index;
        nxt_cnt    = blank_cnt;
        nxt_digits = shadow_digits;
        nxt_dots   = shadow_dots;
        nxt_bz     = shadow_bz;
        nxt_frame  = 1'b0;
        advance    = 1'b0;
        if (step_p3) begin
            case (state)
                IDLE: begin
                    nxt_state  = SHOW;
                    nxt_index  = '0;
                    nxt_digits = digitsIn;
                    nxt_dots   = dotMask;
                    nxt_bz     = blankZeros;
                    nxt_frame  = 1'b1;
                end
                SHOW: begin
                    if (BLANK_TICKS > 0) begin
                        nxt_state = BLANK;
                        nxt_cnt   = BLANK_LOAD;
                    end else begin
                        advance = 1'b1;
                    end
                end
                BLANK: begin
                    if (blank_cnt == 4'd0) begin
                        nxt_state = SHOW;
                        advance   = 1'b1;
                    end else begin
                        nxt_cnt = blank_cnt - 4'd1;
                    end
                end
                default: nxt_state = IDLE;
            endcase
            if (advance) begin
                if (index == LAST_IDX) begin
                    nxt_index  = '0;
                    nxt_digits = digitsIn;
                    nxt_dots   = dotMask;
                    nxt_bz     = blankZeros;
                    nxt_frame  = 1'b1;
                end else begin
                    nxt_index = index + IDX_W'(1);
                end
            end
        end
    end

    // A digit is a leading zero when it and every more significant digit are 0.
    always_comb begin
        zero_run = nxt_bz;
        lz_mask  = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run   = zero_run & (nxt_digits[i*4 +: 4] == 4'd0);
            lz_mask[i] = zero_run;
        end
    end

    assign cur_value = nxt_digits[nxt_index*4 +: 4];
    assign cur_blank = lz_mask[nxt_index];

    seg7_decoder u_decoder (
        .value (cur_value),
        .blank (cur_blank),
        .seg   (dec_seg)
    );

    always_comb begin
        lit       = (nxt_state == SHOW);
        seg_lit   = lit ? dec_seg : SEG_OFF;
        dot_lit   = lit & nxt_dots[nxt_index];
        anode_lit = '0;
        if (lit) anode_lit[nxt_index] = 1'b1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_p0       <= 1'b0;
            sync_p1       <= 1'b0;
            sync_p2       <= 1'b0;
            step_p3       <= 1'b0;
            state         <= IDLE;
            index         <= '0;
            blank_cnt     <= 4'd0;
            shadow_digits <= '0;
            shadow_dots   <= '0;
            shadow_bz     <= 1'b0;
            segments      <= {7{POL}};
            dot           <= POL;
            anodes        <= {DIGITS{POL}};
            frameStart    <= 1'b0;
        end else begin
            // 2-FF synchronizer, edge register, registered rising-edge step
            sync_p0       <= scanTick;
            sync_p1       <= sync_p0;
            sync_p2       <= sync_p1;
            step_p3       <= sync_p1 & ~sync_p2;
            state         <= nxt_state;
            index         <= nxt_index;
            blank_cnt     <= nxt_cnt;
            shadow_digits <= nxt_digits;
            shadow_dots   <= nxt_dots;
            shadow_bz     <= nxt_bz;
            segments      <= seg_lit ^ {7{POL}};
            dot           <= dot_lit ^ POL;
            anodes        <= anode_lit ^ {DIGITS{POL}};
            frameStart    <= nxt_frame;
        end
    end

endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner: one instance with one dead-time step,
// one with none; both active-low, four digits, sharing all inputs.
module tb_display_scanner;

    logic        clock = 1'b0;
    logic        reset;
    logic        scanTick;
    logic [15:0] digitsIn;
    logic [3:0]  dotMask;
    logic        blankZeros;

    logic [6:0]  segments, segments0;
    logic        dot, dot0;
    logic [3:0]  anodes, anodes0;
    logic        frameStart, frameStart0;

    int checks   = 0;
    int failures = 0;
    logic mon0   = 1'b0;

    // Active-low glyphs as seen on the pins
    localparam logic [6:0] G_OFF  = 7'h7F;
    localparam logic [6:0] G_0    = 7'h40;
    localparam logic [6:0] G_1    = 7'h79;
    localparam logic [6:0] G_2    = 7'h24;
    localparam logic [6:0] G_3    = 7'h30;
    localparam logic [6:0] G_4    = 7'h19;
    localparam logic [6:0] G_5    = 7'h12;
    localparam logic [6:0] G_7    = 7'h78;
    localparam logic [6:0] G_DASH = 7'h3F;

    display_scanner #(.DIGITS(4), .BLANK_TICKS(1), .ACTIVE_LOW(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .scanTick   (scanTick),
        .digitsIn   (digitsIn),
        .dotMask    (dotMask),
        .blankZeros (blankZeros),
        .segments   (segments),
        .dot        (dot),
        .anodes     (anodes),
        .frameStart (frameStart)
    );

    display_scanner #(.DIGITS(4), .BLANK_TICKS(0), .ACTIVE_LOW(1)) dut0 (
        .clock      (clock),
        .reset      (reset),
        .scanTick   (scanTick),
        .digitsIn   (digitsIn),
        .dotMask    (dotMask),
        .blankZeros (blankZeros),
        .segments   (segments0),
        .dot        (dot0),
        .anodes     (anodes0),
        .frameStart (frameStart0)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg,
                           input logic dp);
        chk({tag, ".anodes"}, 32'(anodes), 32'(an));
        chk({tag, ".segments"}, 32'(segments), 32'(seg));
        chk({tag, ".dot"}, 32'(dot), 32'(dp));
    endtask

    // 2 clocks high, 2 clocks low; returns just after the edge where outputs update
    task automatic tick();
        scanTick = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        scanTick = 1'b0;
        repeat (2) @(posedge clock);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // The zero dead-time instance must light exactly one digit every cycle
    always @(negedge clock) begin
        if (mon0) begin
            checks++;
            assert ($countones(~anodes0) == 1) else begin
                failures++;
                $error("FAIL zero_deadtime.one_hot got=%b expected one low bit", anodes0);
            end
        end
    end

    initial begin
        reset      = 1'b1;
        scanTick   = 1'b0;
        digitsIn   = 16'h1234;
        dotMask    = 4'b0000;
        blankZeros = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_out("reset", 4'b1111, G_OFF, 1'b1);
        chk("reset.frameStart", 32'(frameStart), 32'd0);
        chk("reset.anodes0", 32'(anodes0), 32'hF);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("idle.anodes", 32'(anodes), 32'hF);

        // Basic scan 1234 with one dead-time step
        tick();
        chk_out("scan.t1", 4'b1110, G_4, 1'b1);
        chk("scan.t1.frameStart", 32'(frameStart), 32'd1);
        chk("zdt.t1.anodes", 32'(anodes0), 32'hE);
        chk("zdt.t1.frameStart", 32'(frameStart0), 32'd1);
        mon0 = 1'b1;
        @(posedge clock);
        #1;
        chk("scan.t1.frameStart_pulse", 32'(frameStart), 32'd0);
        tick();
        chk_out("scan.t2", 4'b1111, G_OFF, 1'b1);
        chk("zdt.t2.anodes", 32'(anodes0), 32'hD);
        chk("zdt.t2.frameStart", 32'(frameStart0), 32'd0);
        tick();
        chk_out("scan.t3", 4'b1101, G_3, 1'b1);
        tick();
        chk_out("scan.t4", 4'b1111, G_OFF, 1'b1);
        tick();
        chk_out("scan.t5", 4'b1011, G_2, 1'b1);
        chk("scan.t5.frameStart", 32'(frameStart), 32'd0);
        chk("zdt.t5.anodes", 32'(anodes0), 32'hE);
        chk("zdt.t5.frameStart", 32'(frameStart0), 32'd1);
        tick();
        chk_out("scan.t6", 4'b1111, G_OFF, 1'b1);
        tick();
        chk_out("scan.t7", 4'b0111, G_1, 1'b1);
        tick();
        chk_out("scan.t8", 4'b1111, G_OFF, 1'b1);

        // Leading-zero blanking
        digitsIn   = 16'h0050;
        blankZeros = 1'b1;
        tick();
        chk_out("lz.d0", 4'b1110, G_0, 1'b1);
        chk("lz.frameStart", 32'(frameStart), 32'd1);
        tick();
        tick();
        chk_out("lz.d1", 4'b1101, G_5, 1'b1);
        tick();
        tick();
        chk_out("lz.d2", 4'b1011, G_OFF, 1'b1);
        tick();
        tick();
        chk_out("lz.d3", 4'b0111, G_OFF, 1'b1);
        tick();
        digitsIn = 16'h0000;
        tick();
        chk_out("lz0.d0", 4'b1110, G_0, 1'b1);
        tick();
        tick();
        chk_out("lz0.d1", 4'b1101, G_OFF, 1'b1);
        tick_n(5);

        // Error glyph and decimal point
        digitsIn   = 16'h00A7;
        dotMask    = 4'b0010;
        blankZeros = 1'b0;
        tick();
        chk_out("err.d0", 4'b1110, G_7, 1'b1);
        tick();
        tick();
        chk_out("err.d1", 4'b1101, G_DASH, 1'b0);
        tick_n(5);

        // Frame coherence
        digitsIn = 16'h1111;
        dotMask  = 4'b0000;
        tick();
        chk_out("coh.d0", 4'b1110, G_1, 1'b1);
        tick();
        tick();
        chk_out("coh.d1", 4'b1101, G_1, 1'b1);
        digitsIn = 16'h2222;
        tick();
        tick();
        chk_out("coh.d2", 4'b1011, G_1, 1'b1);
        tick();
        tick();
        chk_out("coh.d3", 4'b0111, G_1, 1'b1);
        tick();
        tick();
        chk_out("coh.next_d0", 4'b1110, G_2, 1'b1);
        chk("coh.frameStart", 32'(frameStart), 32'd1);
        tick();
        tick();
        chk_out("coh.next_d1", 4'b1101, G_2, 1'b1);
        tick();
        tick();
        chk_out("coh.next_d2", 4'b1011, G_2, 1'b1);

        // Reset mid-frame while digit 2 is lit
        mon0  = 1'b0;
        reset = 1'b1;
        #1;
        chk_out("midrst", 4'b1111, G_OFF, 1'b1);
        chk("midrst.frameStart", 32'(frameStart), 32'd0);
        chk("midrst.anodes0", 32'(anodes0), 32'hF);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clock);
        #1;
        chk_out("midrst.idle", 4'b1111, G_OFF, 1'b1);

        // Narrow 1-clock pulse: outcome not defined, so resync with reset afterwards
        scanTick = 1'b1;
        @(posedge clock);
        #1;
        scanTick = 1'b0;
        repeat (8) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        chk_out("narrow.resync", 4'b1111, G_OFF, 1'b1);

        // 2-high/2-low ticks: one step per rising edge
        tick();
        chk_out("min_tick.t1", 4'b1110, G_2, 1'b1);
        chk("min_tick.frameStart", 32'(frameStart), 32'd1);
        tick();
        chk_out("min_tick.t2", 4'b1111, G_OFF, 1'b1);
        tick();
        chk_out("min_tick.t3", 4'b1101, G_2, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
# display_scanner

Time-multiplexed 7-segment display driver that consumes the divider's slow display tick. It synchronizes the tick into the system clock domain and scans DIGITS common-anode digits, one at a time, with a programmable dead-time between digits. It decodes frame-coherent BCD values, applies optional leading-zero blanking, and drives the board's segment and anode pins directly.

## Interface
- DIGITS, 4: number of multiplexed digits. Legal range 2..8.
- BLANK_TICKS, 1: number of scan steps with all anodes off between two digits. Legal range 0..15.
- ACTIVE_LOW, 1: 1 means segments, dot and anodes are driven low to light; 0 means driven high.

- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- scanTick  in  1  divided display clock from the frequency divider. It is treated as asynchronous.
- digitsIn  in  4*DIGITS  BCD digit values. Nibble 0 is the least significant (rightmost) digit.
- dotMask  in  DIGITS  decimal-point enable per digit.
- blankZeros  in  1  enables leading-zero blanking.
- segments  out  7  segment pins, bit order {g,f,e,d,c,b,a}.
- dot  out  1  decimal-point pin.
- anodes  out  DIGITS  digit enables. Bit i drives digit i.
- frameStart  out  1  one-clock pulse on the first cycle digit 0 is lit.

## Operation
- **Synchronizer:** scanTick passes through a 2-FF synchronizer plus one edge register. step = rising edge, a 1-clock pulse. Falling edges are ignored.
- **FSM states:** IDLE, SHOW, BLANK.
  - IDLE: entered at reset; all outputs off. On step: latch digitsIn, dotMask and blankZeros into shadow registers; set index = 0; go to SHOW; pulse frameStart.
  - SHOW: anodes[index] lit; segments and dot come from shadow digit[index]. On step:
    - if BLANK_TICKS > 0, go to BLANK and load blankCnt = BLANK_TICKS-1;
    - if BLANK_TICKS = 0, advance index and stay in SHOW.
  - BLANK: all anodes, segments and dot off. On step:
    - if blankCnt = 0, advance index and go to SHOW;
    - otherwise decrement blankCnt.
- **Advance index:** if index = DIGITS-1, wrap to 0, re-latch the shadow registers and pulse frameStart. Otherwise increment index.
- **Decode:** values 0-9 use standard glyphs. Values 10-15 show a dash (g only) as an error glyph.
- **Leading-zero blanking:** when shadow blankZeros = 1, digit i is blanked if its value and the values of all more significant digits are 0. Digit 0 is never blanked. A blanked digit still shows its dot if dotMask[i] = 1. Its anode stays lit.
- **Polarity:** ACTIVE_LOW inverts segments, dot and anodes at the output registers only.
- **Input coherence:** changes to digitsIn, dotMask or blankZeros during a frame have no effect until the next wrap.
- **Output glitches:** all outputs are registered, so there are no glitches.
- **Anode exclusivity:** at most one anode is lit in any cycle.

## Timing
- **Reset values (asynchronous):**
  - state = IDLE, index = 0, blankCnt = 0, shadow registers = 0, synchronizer = 0;
  - anodes, segments and dot all at their off level (all 1 when ACTIVE_LOW);
  - frameStart = 0.
- **Latency:** step is asserted 3 clocks after a scanTick rising edge. Outputs change on the clock after step, i.e. 4 clocks after the scanTick edge.
- **Period:** each digit is lit for 1 step period. One frame lasts DIGITS*(1+BLANK_TICKS) step periods.
- **frameStart** is coincident with the first lit cycle of digit 0.
- **Reset mid-frame:** outputs go off immediately. After release, the block waits in IDLE for the next step.
- **Tick rate:** scanTick must stay high and low for at least 2 clocks each. Faster ticks are out of specification.

## Structure
- **Package display_pkg:**
  - state enum {IDLE, SHOW, BLANK};
  - SEG_OFF = 7'b0000000 and SEG_DASH = 7'b1000000, both active-high internal encodings;
  - the 16-entry glyph constant table.
- **Sub-module seg7_decoder:** combinational, 4-bit value plus blank input to 7-bit active-high segments. It is reused by other display blocks.
- The synchronizer, edge detector and FSM are implemented inline.

## Test plan
- **Reset then scan:** reset, then digitsIn = 16'h1234, BLANK_TICKS = 1, ACTIVE_LOW = 1, 8 ticks.
  - Expect the anode sequence 1110, 1111, 1101, 1111, 1011, 1111, 0111, 1111.
  - Expect segments for 4,-,3,-,2,-,1,- (shown with no segments during blanks).
  - Expect frameStart once, 4 clocks after the first tick.
- **Leading zeros:** digitsIn = 16'h0050, blankZeros = 1. Expect digits 3 and 2 blank, digit 1 = "5", digit 0 = "0".
  - With 16'h0000, only digit 0 shows "0".
- **Error glyph and dot:** digitsIn = 16'h00A7, dotMask = 4'b0010. Expect digit 0 = "7", digit 1 = dash with dot on.
- **Frame coherence:** change digitsIn from 16'h1111 to 16'h2222 while digit 1 is lit.
  - Expect digits 2 and 3 to still show "1".
  - Expect "2" on all digits from the next frameStart.
- **Zero dead-time:** BLANK_TICKS = 0, DIGITS = 4. Expect no all-off step, a 4-step frame, and exactly one anode low every cycle after the first tick.
- **Reset mid-frame and narrow tick:** assert reset during digit 2. Expect anodes = 1111 in the same cycle.
  - A 1-clock scanTick pulse may be missed.
  - A 2-clock high / 2-clock low tick produces exactly one step per edge.
